mult_share_arbiter: RTL and testbench

Shares one multi-cycle 32x32 unsigned CompMultiplier between two requesters.
- Arbitrates round-robin between the requesters and latches the winner's operands.
- Sequences the multiplier's Rst/Run/Rdy protocol: clear pulse, one idle cycle, Run held until Rdy rises.
- Returns the 64-bit product with a one-hot done pulse.
- Aborts with an error if Rdy never arrives.

---
 rtl/mult_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one multi-cycle 32x32 unsigned multiplier between two requesters.
// A round-robin winner is picked in IDLE and its operands are latched. The
// multiplier is then sequenced through a one-cycle clear (CLR), one idle
// cycle (GAP), and Run held until a rising edge of Rdy (RUN). The product is
// returned with a one-cycle Done pulse to the owner (DONE). If no Rdy edge
// arrives within TIMEOUT RUN cycles the operation is aborted: Err pulses with
// Done and the product is reported as zero.
//
// Ports:
//   clk       system clock, rising edge
//   Rst       asynchronous active-low reset
//   Req[1:0]  per-requester request, held until the matching Done bit pulses
//   A0/B0     requester 0 operands; A1/B1 requester 1 operands
//   Gnt[1:0]  one-hot current owner, high from CLR through DONE
//   Done[1:0] one-hot one-cycle pulse to the owner when its result is valid
//   Err       pulses with Done when the operation timed out
//   Prod_out  last result, held until the next DONE
//   M_Mult/M_Mul  operands driven to the multiplier
//   M_Run/M_Rst   multiplier run and synchronous clear (active-high)
//   M_Prod/M_Rdy  multiplier product and ready
module mult_share_arbiter #(
  parameter int unsigned TIMEOUT = 128,
  parameter int unsigned CW      = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [1:0]  Req,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  output logic [1:0]  Gnt,
  output logic [1:0]  Done,
  output logic        Err,
  output logic [63:0] Prod_out,
  output logic [31:0] M_Mult,
  output logic [31:0] M_Mul,
  output logic        M_Run,
  output logic        M_Rst,
  input  logic [63:0] M_Prod,
  input  logic        M_Rdy
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StGap,
    StRun,
    StDone
  } state_e;

  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  gnt_q;
  logic        last_grant_q;
  logic        rdy_q;
  logic [CW-1:0] cnt_q;
  logic [63:0] prod_q;
  logic        err_q;
  logic [31:0] mult_q;
  logic [31:0] mul_q;

  logic        rdy_rise;
  logic        pick;

  always_comb begin
    // Only an edge counts: a level-high Rdy may be left over from the
    // previous operation.
    rdy_rise = M_Rdy & ~rdy_q;
    // Winner index; on a tie, the requester that did not win last time.
    case (Req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant_q;
      default: pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      last_grant_q <= 1'b1;
      rdy_q        <= 1'b0;
      cnt_q        <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
      mult_q       <= '0;
      mul_q        <= '0;
    end else begin
      rdy_q <= M_Rdy;
      case (state_q)
        StIdle: begin
          if (Req != 2'b00) begin
            gnt_q        <= pick ? 2'b10 : 2'b01;
            last_grant_q <= pick;
            mult_q       <= pick ? A1 : A0;
            mul_q        <= pick ? B1 : B0;
            state_q      <= StClr;
          end
        end
        StClr: begin
          state_q <= StGap;
        end
        StGap: begin
          cnt_q   <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (rdy_rise) begin
            prod_q  <= M_Prod;
            err_q   <= 1'b0;
            state_q <= StDone;
          end else if (cnt_q == CntMax) begin
            prod_q  <= '0;
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          gnt_q   <= 2'b00;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Decoded from the state register only, so reset drops them immediately.
  always_comb begin
    M_Rst = (state_q == StClr);
    M_Run = (state_q == StRun);
    Done  = (state_q == StDone) ? gnt_q : 2'b00;
  end

  assign Gnt      = gnt_q;
  assign Err      = err_q;
  assign Prod_out = prod_q;
  assign M_Mult   = mult_q;
  assign M_Mul    = mul_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed operations against a small
// multiplier model with programmable Rdy latency. Instance u_dut uses the
// default TIMEOUT; u_dut_to uses TIMEOUT=8 for the abort cases. Only the
// selected instance sees requests and drives the model.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        Rst;
  logic [1:0]  req;
  logic        sel;
  logic [31:0] A0, B0, A1, B1;

  logic [1:0]  req_a, req_b;
  logic [1:0]  gnt_a, gnt_b, done_a, done_b;
  logic        err_a, err_b, run_a, run_b, mrst_a, mrst_b;
  logic [63:0] prod_a, prod_b;
  logic [31:0] mult_a, mult_b, mul_a, mul_b;

  logic [1:0]  mon_gnt, mon_done;
  logic        mon_err, mon_run, mon_mrst;
  logic [63:0] mon_prod;
  logic [31:0] mon_mult, mon_mul;

  // Multiplier model state.
  int          mode = 0;   // 0 normal, 1 never ready, 2 stale Rdy at start
  int          lat  = 33;
  int          mdl_cnt = 0;
  logic        mdl_rdy = 1'b0;
  logic [63:0] mdl_prod = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign req_a = sel ? 2'b00 : req;
  assign req_b = sel ? req : 2'b00;

  assign mon_gnt  = sel ? gnt_b  : gnt_a;
  assign mon_done = sel ? done_b : done_a;
  assign mon_err  = sel ? err_b  : err_a;
  assign mon_run  = sel ? run_b  : run_a;
  assign mon_mrst = sel ? mrst_b : mrst_a;
  assign mon_prod = sel ? prod_b : prod_a;
  assign mon_mult = sel ? mult_b : mult_a;
  assign mon_mul  = sel ? mul_b  : mul_a;

  mult_share_arbiter u_dut (
    .clk      (clk),
    .Rst      (Rst),
    .Req      (req_a),
    .A0       (A0),
    .B0       (B0),
    .A1       (A1),
    .B1       (B1),
    .Gnt      (gnt_a),
    .Done     (done_a),
    .Err      (err_a),
    .Prod_out (prod_a),
    .M_Mult   (mult_a),
    .M_Mul    (mul_a),
    .M_Run    (run_a),
    .M_Rst    (mrst_a),
    .M_Prod   (mdl_prod),
    .M_Rdy    (mdl_rdy)
  );

  mult_share_arbiter #(
    .TIMEOUT (8),
    .CW      (16)
  ) u_dut_to (
    .clk      (clk),
    .Rst      (Rst),
    .Req      (req_b),
    .A0       (A0),
    .B0       (B0),
    .A1       (A1),
    .B1       (B1),
    .Gnt      (gnt_b),
    .Done     (done_b),
    .Err      (err_b),
    .Prod_out (prod_b),
    .M_Mult   (mult_b),
    .M_Mul    (mul_b),
    .M_Run    (run_b),
    .M_Rst    (mrst_b),
    .M_Prod   (mdl_prod),
    .M_Rdy    (mdl_rdy)
  );

  // Rdy rises after lat Run cycles; garbage product until then.
  always @(posedge clk) begin
    if (mon_mrst) begin
      mdl_cnt  <= 0;
      mdl_rdy  <= (mode == 2);
      mdl_prod <= 64'hDEAD_BEEF_0BAD_F00D;
    end else if (mon_run) begin
      mdl_cnt <= mdl_cnt + 1;
      if (mode == 2 && mdl_cnt == 3) mdl_rdy <= 1'b0;
      if (mode != 1 && mdl_cnt == lat - 1) begin
        mdl_rdy  <= 1'b1;
        mdl_prod <= {32'b0, mon_mult} * {32'b0, mon_mul};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from IDLE and checks its sequencing and result.
  // drop: Req bits released once Done is seen.
  task automatic run_op(input string name, input logic [1:0] req_set, input logic [1:0] drop,
                        input logic [1:0] exp_owner, input logic [63:0] exp_prod,
                        input logic exp_err, input int exp_run,
                        input logic [31:0] exp_a, input logic [31:0] exp_b);
    int cyc = 0;
    int first_gnt = -1;
    int first_run = -1;
    int run_n = 0;
    int mrst_n = 0;
    int gnt_bad = 0;
    logic got = 1'b0;
    req = req_set;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mon_gnt != 2'b00 && first_gnt < 0) first_gnt = cyc;
      if (mon_gnt != 2'b00 && mon_gnt != exp_owner) gnt_bad++;
      if (mon_run) begin
        run_n++;
        if (first_run < 0) first_run = cyc;
      end
      if (mon_mrst) mrst_n++;
      if (mon_done != 2'b00) got = 1'b1;
    end
    check({name, ".done_seen"}, 64'(got), 64'd1);
    check({name, ".done"}, 64'(mon_done), 64'(exp_owner));
    check({name, ".gnt_at_done"}, 64'(mon_gnt), 64'(exp_owner));
    check({name, ".gnt_other"}, 64'(gnt_bad), 64'd0);
    check({name, ".prod"}, mon_prod, exp_prod);
    check({name, ".err"}, 64'(mon_err), 64'(exp_err));
    check({name, ".run_cycles"}, 64'(run_n), 64'(exp_run));
    check({name, ".mrst_cycles"}, 64'(mrst_n), 64'd1);
    check({name, ".gnt_to_run"}, 64'(first_run - first_gnt), 64'd2);
    check({name, ".m_mult"}, 64'(mon_mult), 64'(exp_a));
    check({name, ".m_mul"}, 64'(mon_mul), 64'(exp_b));
    req = req & ~drop;
    @(negedge clk);
    check({name, ".done_pulse"}, 64'(mon_done), 64'd0);
    check({name, ".gnt_released"}, 64'(mon_gnt), 64'd0);
    check({name, ".err_pulse"}, 64'(mon_err), 64'd0);
    check({name, ".prod_hold"}, mon_prod, exp_prod);
  endtask

  initial begin
    int waited;
    int done_n;
    Rst = 1'b0;
    req = 2'b00;
    sel = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    repeat (3) @(negedge clk);
    check("rst.gnt", 64'(gnt_a), 64'd0);
    check("rst.done", 64'(done_a), 64'd0);
    check("rst.err", 64'(err_a), 64'd0);
    check("rst.prod", prod_a, 64'd0);
    check("rst.mult_mul", {mult_a, mul_a}, 64'd0);
    check("rst.run_mrst", {62'd0, run_a, mrst_a}, 64'd0);
    check("rst.to_gnt", 64'(gnt_b), 64'd0);
    Rst = 1'b1;
    @(negedge clk);

    // Tie after reset: requester 0 first, then 1.
    mode = 0; lat = 33;
    A0 = 32'hFFFF_FFFF; B0 = 32'hFFFF_FFFF; A1 = 32'd7; B1 = 32'd9;
    run_op("tie0", 2'b11, 2'b01, 2'b01, 64'hFFFF_FFFE_0000_0001, 1'b0, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("tie1", 2'b10, 2'b10, 2'b10, 64'd63, 1'b0, 34, 32'd7, 32'd9);

    // Fairness: both held for four operations.
    lat = 5;
    A0 = 32'd100; B0 = 32'd3; A1 = 32'd20; B1 = 32'd21;
    run_op("fair0", 2'b11, 2'b00, 2'b01, 64'd300, 1'b0, 6, 32'd100, 32'd3);
    run_op("fair1", 2'b11, 2'b00, 2'b10, 64'd420, 1'b0, 6, 32'd20, 32'd21);
    run_op("fair2", 2'b11, 2'b00, 2'b01, 64'd300, 1'b0, 6, 32'd100, 32'd3);
    run_op("fair3", 2'b11, 2'b11, 2'b10, 64'd420, 1'b0, 6, 32'd20, 32'd21);

    // Single request.
    lat = 33;
    A0 = 32'd3; B0 = 32'd5;
    run_op("single", 2'b01, 2'b01, 2'b01, 64'd15, 1'b0, 34, 32'd3, 32'd5);

    // Stale Rdy: only the re-rise completes.
    mode = 2; lat = 10;
    A0 = 32'h0001_0000; B0 = 32'h0001_0000;
    run_op("stale", 2'b01, 2'b01, 2'b01, 64'h1_0000_0000, 1'b0, 11,
           32'h0001_0000, 32'h0001_0000);

    // Asynchronous reset in the middle of RUN.
    mode = 0; lat = 33;
    A0 = 32'd11; B0 = 32'd13;
    req = 2'b01;
    waited = 0;
    while (!run_a && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("arst.reached_run", 64'(run_a), 64'd1);
    repeat (5) @(negedge clk);
    #2 Rst = 1'b0;
    #1;
    check("arst.run", 64'(run_a), 64'd0);
    check("arst.gnt", 64'(gnt_a), 64'd0);
    check("arst.done_mrst", {62'd0, done_a}, 64'd0);
    check("arst.prod", prod_a, 64'd0);
    req = 2'b00;
    @(negedge clk);
    Rst = 1'b1;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a != 2'b00) done_n++;
    end
    check("arst.no_done", 64'(done_n), 64'd0);
    A1 = 32'd2; B1 = 32'd4;
    run_op("post_rst", 2'b10, 2'b10, 2'b10, 64'd8, 1'b0, 34, 32'd2, 32'd4);

    // TIMEOUT=8 instance.
    sel = 1'b1;
    @(negedge clk);
    mode = 1;
    A0 = 32'd5; B0 = 32'd5;
    run_op("timeout", 2'b01, 2'b01, 2'b01, 64'd0, 1'b1, 8, 32'd5, 32'd5);
    // Rdy edge arriving on the last counted cycle still wins.
    mode = 0; lat = 7;
    A0 = 32'd10; B0 = 32'd11;
    run_op("edge_at_limit", 2'b01, 2'b01, 2'b01, 64'd110, 1'b0, 8, 32'd10, 32'd11);
    lat = 3;
    A0 = 32'd6; B0 = 32'd7;
    run_op("after_timeout", 2'b01, 2'b01, 2'b01, 64'd42, 1'b0, 4, 32'd6, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
